// File: rtl/encoder_period_meter.sv
// Quadrature encoder front end: synchronizes and deglitches A/B, tracks x4 position,
// and measures the clk-cycle period between filtered A rising edges for the speed loop.
module encoder_period_meter #(
   parameter int unsigned         FILTER_LEN = 4,
   parameter int unsigned         PERIOD_W   = 16,
   parameter logic [PERIOD_W-1:0] TIMEOUT    = {PERIOD_W{1'b1}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                meas_en,
   input  logic                encoder_a,
   input  logic                encoder_b,
   output logic [PERIOD_W-1:0] period_out,
   output logic                period_valid,
   output logic                direction,
   output logic [15:0]         position,
   output logic                stalled,
   output logic                qerr
);

   typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

   localparam logic [3:0]          FILT_LAST = 4'(FILTER_LEN - 1);
   localparam logic [PERIOD_W-1:0] CNT_ZERO  = {PERIOD_W{1'b0}};
   localparam logic [PERIOD_W-1:0] CNT_ONE   = {{(PERIOD_W-1){1'b0}}, 1'b1};

   // Channel vectors are packed as {A, B} so the filtered pair reads directly as a Gray code
   logic [1:0] meta_r, sync_r, filt_r, prev_r;
   logic [3:0] fcnt_r [2];

   logic [1:0]          quad_s;
   logic                a_rise_s;
   logic [15:0]         pos_nxt_s, position_r;
   logic                qerr_nxt_s, qerr_r;

   state_t              state_r, state_nxt_s;
   logic [PERIOD_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
   logic [PERIOD_W-1:0] period_r, period_nxt_s;
   logic                valid_r, valid_nxt_s;
   logic                stalled_r, stalled_nxt_s;
   logic                dir_r, dir_nxt_s;

   // Classifies a filtered {A,B} transition: 00 none, 01 forward, 10 reverse, 11 illegal
   function automatic logic [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] step;
      case ({prev, cur})
         4'b0010, 4'b1011, 4'b1101, 4'b0100: step = 2'b01;
         4'b1000, 4'b1110, 4'b0111, 4'b0001: step = 2'b10;
         4'b0011, 4'b1100, 4'b0110, 4'b1001: step = 2'b11;
         default:                            step = 2'b00;
      endcase
      return step;
   endfunction

   // Two-flop synchronizer, per-channel glitch filter and previous-level register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_r    <= 2'b00;
         sync_r    <= 2'b00;
         filt_r    <= 2'b00;
         prev_r    <= 2'b00;
         fcnt_r[0] <= 4'd0;
         fcnt_r[1] <= 4'd0;
      end else begin
         meta_r <= {encoder_a, encoder_b};
         sync_r <= meta_r;
         prev_r <= filt_r;
         for (int ch = 0; ch < 2; ch++) begin
            if (sync_r[ch] != filt_r[ch]) begin
               if (fcnt_r[ch] == FILT_LAST) begin
                  filt_r[ch] <= ~filt_r[ch];
                  fcnt_r[ch] <= 4'd0;
               end else begin
                  fcnt_r[ch] <= fcnt_r[ch] + 4'd1;
               end
            end else begin
               fcnt_r[ch] <= 4'd0;
            end
         end
      end
   end

   assign quad_s   = quad_step(prev_r, filt_r);
   assign a_rise_s = filt_r[1] & ~prev_r[1];

   // Next position and error pulse from the decoded transition
   always_comb begin
      pos_nxt_s  = position_r;
      qerr_nxt_s = 1'b0;
      case (quad_s)
         2'b01:   pos_nxt_s  = position_r + 16'd1;
         2'b10:   pos_nxt_s  = position_r - 16'd1;
         2'b11:   qerr_nxt_s = 1'b1;
         default: pos_nxt_s  = position_r;
      endcase
   end

   // Position counter and qerr pulse registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         position_r <= 16'd0;
         qerr_r     <= 1'b0;
      end else begin
         position_r <= pos_nxt_s;
         qerr_r     <= qerr_nxt_s;
      end
   end

   assign cnt_inc_s = (cnt_r == TIMEOUT) ? cnt_r : cnt_r + CNT_ONE;

   // Period FSM next state; an A rise takes priority over a simultaneous timeout
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      period_nxt_s  = period_r;
      valid_nxt_s   = 1'b0;
      stalled_nxt_s = stalled_r;
      dir_nxt_s     = dir_r;
      if (!meas_en) begin
         state_nxt_s = IDLE;
         cnt_nxt_s   = CNT_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (a_rise_s) begin
                  cnt_nxt_s   = CNT_ONE;
                  state_nxt_s = ARMED;
               end else begin
                  cnt_nxt_s   = cnt_inc_s;
               end
            end
            ARMED: begin
               if (a_rise_s) begin
                  period_nxt_s  = cnt_r;
                  valid_nxt_s   = 1'b1;
                  cnt_nxt_s     = CNT_ONE;
                  stalled_nxt_s = 1'b0;
                  dir_nxt_s     = ~filt_r[0];
               end else if (cnt_r == TIMEOUT) begin
                  period_nxt_s  = TIMEOUT;
                  valid_nxt_s   = 1'b1;
                  stalled_nxt_s = 1'b1;
                  state_nxt_s   = IDLE;
               end else begin
                  cnt_nxt_s     = cnt_inc_s;
               end
            end
            default: begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end
         endcase
      end
   end

   // Period FSM state and registered measurement outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         period_r  <= CNT_ZERO;
         valid_r   <= 1'b0;
         stalled_r <= 1'b1;
         dir_r     <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         period_r  <= period_nxt_s;
         valid_r   <= valid_nxt_s;
         stalled_r <= stalled_nxt_s;
         dir_r     <= dir_nxt_s;
      end
   end

   assign period_out   = period_r;
   assign period_valid = valid_r;
   assign direction    = dir_r;
   assign position     = position_r;
   assign stalled      = stalled_r;
   assign qerr         = qerr_r;

endmodule
